// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio framing path: sample format,
// offset-binary conversion and the framer state encoding.
package audio_pkg;

  localparam int SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] ADC_MID = 12'h800;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } framer_state_t;

  // Offset-binary to two's complement is a flip of the MSB.
  function automatic sample_t adc_to_signed(input logic [SAMPLE_W-1:0] code);
    return sample_t'(code ^ ADC_MID);
  endfunction

  // Magnitude as unsigned; -2048 maps to 2048 without saturation.
  function automatic logic [SAMPLE_W-1:0] abs_sample(input sample_t x);
    logic [SAMPLE_W-1:0] u;
    u = x;
    return x[SAMPLE_W-1] ? (~u + 12'd1) : u;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO. A read frees a slot in the same
// cycle, so a write into a full FIFO is accepted when it coincides with a read.
module sample_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head is masked while empty so stale storage never shows after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/audio_framer.sv
// Converts ADC samples to signed, groups them into frames, buffers them in a
// FWFT FIFO and reports per-frame sum|x| energy with a voice-activity flag.
module audio_framer
  import audio_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int DEPTH     = 64,
  parameter int THRESH    = 4096,
  localparam int ACC_W    = SAMPLE_W + $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                sample_tick,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [ACC_W-1:0]    frame_energy,
  output logic                energy_valid,
  output logic                vad,
  output logic                overflow,
  output framer_state_t       state
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  // Stream: a beat transfers on a cycle where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_sample/out_last hold their value.
  framer_state_t        state_d;
  sample_t              conv_sample;
  logic                 conv_valid;
  logic [IDX_W-1:0]     idx;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     sum;
  logic [SAMPLE_W-1:0]  abs_x;
  logic                 accept_tick;
  logic                 rd;
  logic                 wr_ok;
  logic                 at_last;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [SAMPLE_W:0]    fifo_head;

  assign accept_tick = sample_tick && (state == RUN || state == FINISH);
  assign out_valid   = !fifo_empty;
  assign rd          = out_valid && out_ready;
  assign wr_ok       = conv_valid && (!fifo_full || rd);
  assign at_last     = (idx == IDX_W'(FRAME_LEN - 1));
  assign abs_x       = abs_sample(conv_sample);
  assign sum         = acc + ACC_W'(abs_x);
  assign out_last    = fifo_head[SAMPLE_W];
  assign out_sample  = fifo_head[SAMPLE_W-1:0];

  sample_fifo #(
    .WIDTH (SAMPLE_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_data ({at_last, conv_sample}),
    .rd_en   (out_ready),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A sample still in the conversion stage counts as part of the open frame.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = (idx == '0 && !conv_valid) ? IDLE : FINISH;
      FINISH:  if ((wr_ok && at_last) || (idx == '0 && !conv_valid)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      conv_sample  <= '0;
      conv_valid   <= 1'b0;
      idx          <= '0;
      acc          <= '0;
      frame_energy <= '0;
      energy_valid <= 1'b0;
      vad          <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_d;
      conv_valid   <= accept_tick;
      energy_valid <= 1'b0;
      if (accept_tick) conv_sample <= adc_to_signed(adc_data);
      if (conv_valid && !wr_ok) overflow <= 1'b1;
      // Dropped samples leave index and accumulator untouched.
      if (wr_ok) begin
        if (at_last) begin
          idx          <= '0;
          acc          <= '0;
          frame_energy <= sum;
          vad          <= (sum > ACC_W'(THRESH));
          energy_valid <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_framer.sv
// Directed bench for audio_framer with small frame/FIFO sizes; a stream and
// energy scoreboard run alongside the directed step checks.
module tb_audio_framer;
  import audio_pkg::*;

  localparam int FRAME_LEN = 8;
  localparam int DEPTH     = 16;
  localparam int THRESH    = 1000;
  localparam int ACC_W     = 12 + $clog2(FRAME_LEN);

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [11:0]       adc_data;
  logic              sample_tick;
  logic [11:0]       out_sample;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [ACC_W-1:0]  frame_energy;
  logic              energy_valid;
  logic              vad;
  logic              overflow;
  framer_state_t     state;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_start;

  logic [12:0] exp_q[$];
  logic [15:0] en_q[$];
  logic [12:0] exp_word;
  logic [15:0] en_word;

  audio_framer #(
    .FRAME_LEN (FRAME_LEN),
    .DEPTH     (DEPTH),
    .THRESH    (THRESH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .adc_data     (adc_data),
    .sample_tick  (sample_tick),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .frame_energy (frame_energy),
    .energy_valid (energy_valid),
    .vad          (vad),
    .overflow     (overflow),
    .state        (state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_sample"},   32'(out_sample),   32'd0);
    check({tag, "_out_valid"},    32'(out_valid),    32'd0);
    check({tag, "_out_last"},     32'(out_last),     32'd0);
    check({tag, "_frame_energy"}, 32'(frame_energy), 32'd0);
    check({tag, "_energy_valid"}, 32'(energy_valid), 32'd0);
    check({tag, "_vad"},          32'(vad),          32'd0);
    check({tag, "_overflow"},     32'(overflow),     32'd0);
    check({tag, "_state"},        32'(state),        32'(IDLE));
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic tick(input logic [11:0] code);
    @(posedge clk); #1;
    adc_data    = code;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  // Scoreboard: stream beats and energy reports, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("stream_unexpected_beat", 32'({out_last, out_sample}), 32'h1ffff);
      end else begin
        exp_word = exp_q.pop_front();
        check("stream_beat", 32'({out_last, out_sample}), 32'(exp_word));
      end
    end
    if (rst && energy_valid) begin
      if (en_q.size() == 0) begin
        check("energy_unexpected", 32'({vad, frame_energy}), 32'h1ffff);
      end else begin
        en_word = en_q.pop_front();
        check("energy_report", 32'({vad, frame_energy}), 32'(en_word));
      end
    end
  end

  initial begin
    rst = 1'b0; enable = 1'b0; adc_data = '0; sample_tick = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Conversion corners, then four zeros to close the frame
    @(posedge clk); #1 enable = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_to_run", 32'(state), 32'(RUN));
    exp_q.push_back(13'h0000); exp_q.push_back(13'h07ff);
    exp_q.push_back(13'h0800); exp_q.push_back(13'h0fff);
    exp_q.push_back(13'h0000); exp_q.push_back(13'h0000);
    exp_q.push_back(13'h0000); exp_q.push_back(13'h1000);
    en_q.push_back({1'b1, 15'd4096});
    tick(12'h800);
    @(negedge clk);
    check("latency_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_sample", 32'(out_sample), 32'd0);
    tick(12'hfff); tick(12'h000); tick(12'h7ff);
    for (int i = 0; i < 4; i++) tick(12'h800);
    repeat (3) @(negedge clk);
    check("corner_energy", 32'(frame_energy), 32'd4096);
    check("corner_vad", 32'(vad), 32'd1);

    // Loud frame then quiet frame
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 12'h100});
    en_q.push_back({1'b1, 15'd2048});
    for (int i = 0; i < 7; i++) tick(12'h900);
    tick(12'h900);
    @(negedge clk);
    check("energy_pulse_early", 32'(energy_valid), 32'd0);
    @(negedge clk);
    check("energy_pulse", 32'(energy_valid), 32'd1);
    check("loud_energy", 32'(frame_energy), 32'd2048);
    check("loud_vad", 32'(vad), 32'd1);
    @(negedge clk);
    check("energy_pulse_width", 32'(energy_valid), 32'd0);
    check("vad_held", 32'(vad), 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 12'h010});
    en_q.push_back({1'b0, 15'd128});
    for (int i = 0; i < 8; i++) tick(12'h810);
    repeat (3) @(negedge clk);
    check("quiet_energy", 32'(frame_energy), 32'd128);
    check("quiet_vad", 32'(vad), 32'd0);
    check("drained", 32'(exp_q.size()), 32'd0);

    // Stalled downstream: 17 ticks, 16 stored, last one dropped
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 7 || i == 15), 12'(i + 1)});
    en_q.push_back({1'b0, 15'd36});
    en_q.push_back({1'b0, 15'd100});
    for (int i = 0; i < 16; i++) tick(12'h800 + 12'(i + 1));
    repeat (2) @(negedge clk);
    check("full_no_overflow", 32'(overflow), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("stall_head", 32'(out_sample), 32'd1);
    tick(12'h811);
    repeat (2) @(negedge clk);
    check("overflow_set", 32'(overflow), 32'd1);
    check("stall_head_stable", 32'({out_last, out_sample}), 32'd1);
    hs_start = hs_cnt;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("stall_drain_count", 32'(hs_cnt - hs_start), 32'd16);
    check("stall_drain_empty", 32'(out_valid), 32'd0);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-frame with 5 samples buffered (discarded)
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick(12'h900);
    repeat (2) @(negedge clk);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_state", 32'(state), 32'(RUN));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_cleared("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_reset_empty", 32'(out_valid), 32'd0);

    // Enable drops mid-frame: the frame is finished, then IDLE ignores ticks
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("rerun", 32'(state), 32'(RUN));
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 12'h020});
    en_q.push_back({1'b0, 15'd256});
    for (int i = 0; i < 3; i++) tick(12'h820);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("finish_state", 32'(state), 32'(FINISH));
    for (int i = 0; i < 5; i++) tick(12'h820);
    repeat (2) @(negedge clk);
    check("finish_to_idle", 32'(state), 32'(IDLE));
    check("finish_energy", 32'(frame_energy), 32'd256);
    tick(12'h900); tick(12'h900);
    repeat (3) @(negedge clk);
    check("idle_ignores_valid", 32'(out_valid), 32'd0);
    check("idle_no_overflow", 32'(overflow), 32'd0);
    check("idle_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full FIFO with write and read in the same cycle
    @(posedge clk); #1 enable = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("run_again", 32'(state), 32'(RUN));
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 7 || i == 15), 12'(40 + i)});
    en_q.push_back({1'b0, 15'd348});
    en_q.push_back({1'b0, 15'd412});
    for (int i = 0; i < 16; i++) tick(12'h800 + 12'(40 + i));
    repeat (2) @(negedge clk);
    check("simul_full_valid", 32'(out_valid), 32'd1);
    check("simul_pre_overflow", 32'(overflow), 32'd0);
    exp_q.push_back({1'b0, 12'd56});
    @(posedge clk); #1;
    adc_data = 12'h800 + 12'd56;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    out_ready = 1'b1;
    hs_start = hs_cnt;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("simul_no_drop", 32'(overflow), 32'd0);
    check("simul_one_read", 32'(hs_cnt - hs_start), 32'd1);
    check("simul_new_head", 32'(out_sample), 32'd41);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (25) @(negedge clk);
    check("simul_total_reads", 32'(hs_cnt - hs_start), 32'd17);
    check("simul_queue_empty", 32'(exp_q.size()), 32'd0);
    check("simul_drained", 32'(out_valid), 32'd0);
    check("simul_overflow_final", 32'(overflow), 32'd0);
    check("energy_queue_empty", 32'(en_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
